// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Turns a raw asynchronous level (button, switch, external strobe) into a clean
//   synchronous level: SYNC_STAGES-flop synchronizer -> stability counter FSM ->
//   registered sig_out. sig_out only moves after the synchronized input has held
//   a new level for STABLE_CYCLES consecutive samples.
//   Optional feature: define SWITCH_DEBOUNCER_GLITCH_CNT_EN to add the saturating
//   glitch_count output that counts rejected (aborted) level changes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   STABLE | synchronized input matches sig_out, nothing pending
//   CHECK  | candidate level seen, counting consecutive matching samples
module switch_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter bit RESET_LEVEL   = 1'b0,
  parameter int GLITCH_W      = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic sig_out,
  output logic busy
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
  , output logic [GLITCH_W-1:0] glitch_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_debouncer: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("switch_debouncer: STABLE_CYCLES must be >= 2");
  end
  if (GLITCH_W < 1) begin : g_bad_glitch_w
    $error("switch_debouncer: GLITCH_W must be >= 1");
  end

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic                   sig_out_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift chain; resets to RESET_LEVEL so release never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  // FSM state, stability counter and debounced output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= STABLE;
      cnt     <= '0;
      sig_out <= RESET_LEVEL;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sig_out <= sig_out_nx;
    end
  end

  // Next-state logic; in CHECK an abort takes priority over qualification.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sig_out_nx = sig_out;
    case (state)
      STABLE: begin
        if (s != sig_out) begin
          state_nx = CHECK;
          cnt_nx   = CW'(1);
        end
      end
      CHECK: begin
        if (s == sig_out) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          sig_out_nx = s;
          state_nx   = STABLE;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // busy comes straight from the state register, no combinational input path.
  assign busy = (state == CHECK);

`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
  logic                abort;
  logic [GLITCH_W-1:0] glitch_nx;

  assign abort = (state == CHECK) && (s == sig_out);

  // Saturating count of aborted candidates.
  always_comb begin
    glitch_nx = glitch_count;
    if (abort && (glitch_count != {GLITCH_W{1'b1}})) begin
      glitch_nx = glitch_count + GLITCH_W'(1);
    end
  end

  // Glitch counter register; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_count <= '0;
    end else begin
      glitch_count <= glitch_nx;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed testbench for switch_debouncer with default parameters.
// Inputs change on the falling clock edge; outputs are sampled 1 ns after
// each rising edge. Edge numbers count rising edges after an input change.
module tb_switch_debouncer;

  logic clk;
  logic reset_n;
  logic sig_in;
  logic sig_out;
  logic busy;
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
  logic [7:0] glitch_count;
  int exp_glitch;
`endif

  int n_cmp;
  int n_err;

  switch_debouncer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_in  (sig_in),
    .sig_out (sig_out),
    .busy    (busy)
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    , .glitch_count (glitch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait for the next rising edge and step just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sig_in  = 1'b1;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (sig_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sig_out: got %b want 0", sig_out);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    exp_glitch = 0;
    n_cmp++;
    if (glitch_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_glitch: got %0d want 0", glitch_count);
    end
`endif
    repeat (3) @(negedge clk);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sig_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got sig_out=%b busy=%b want 0/0", sig_out, busy);
    end
  endtask

  // Drive sig_in to 'lvl' and check the full 18-edge qualification.
  task automatic test_transition(input logic lvl, input string name);
    @(negedge clk);
    sig_in = lvl;
    for (int e = 1; e <= 20; e++) begin
      step();
      n_cmp++;
      if (sig_out !== ((e >= 18) ? lvl : ~lvl)) begin
        n_err++;
        $display("FAIL %s_sig_out_e%0d: got %b want %b", name, e, sig_out,
                 (e >= 18) ? lvl : ~lvl);
      end
      n_cmp++;
      if (busy !== (e >= 3 && e <= 17)) begin
        n_err++;
        $display("FAIL %s_busy_e%0d: got %b want %b", name, e, busy, (e >= 3 && e <= 17));
      end
    end
  endtask

  task automatic test_short_pulse();
    @(negedge clk);
    sig_in = 1'b1;
    repeat (15) @(negedge clk);
    sig_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++;
      if (sig_out !== 1'b0) begin
        n_err++;
        $display("FAIL short15_sig_out_e%0d: got %b want 0", e, sig_out);
      end
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL short15_busy_after: got %b want 0", busy);
    end
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    exp_glitch++;
    n_cmp++;
    if (glitch_count !== 8'(exp_glitch)) begin
      n_err++;
      $display("FAIL short15_glitch: got %0d want %0d", glitch_count, exp_glitch);
    end
`endif
  endtask

  task automatic test_min_pulse();
    @(negedge clk);
    sig_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 16) begin
        @(negedge clk);
        sig_in = 1'b0;
      end
      n_cmp++;
      if (sig_out !== (e >= 18 && e < 34)) begin
        n_err++;
        $display("FAIL pulse16_sig_out_e%0d: got %b want %b", e, sig_out, (e >= 18 && e < 34));
      end
    end
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    n_cmp++;
    if (glitch_count !== 8'(exp_glitch)) begin
      n_err++;
      $display("FAIL pulse16_glitch: got %0d want %0d", glitch_count, exp_glitch);
    end
`endif
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sig_in = ~sig_in;
      for (int k = 0; k < 3; k++) begin
        step();
        n_cmp++;
        if (sig_out !== 1'b0) begin
          n_err++;
          $display("FAIL toggle_sig_out_i%0d_k%0d: got %b want 0", i, k, sig_out);
        end
      end
    end
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    exp_glitch += 10;
    n_cmp++;
    if (glitch_count !== 8'(exp_glitch)) begin
      n_err++;
      $display("FAIL toggle_glitch: got %0d want %0d", glitch_count, exp_glitch);
    end
`endif
    test_transition(1'b1, "toggle_final");
  endtask

  task automatic test_reset_mid_check();
    @(negedge clk);
    sig_in = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midchk_busy_before: got %b want 1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (sig_out !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midchk_async_reset: got sig_out=%b busy=%b want 0/0", sig_out, busy);
    end
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    exp_glitch = 0;
    n_cmp++;
    if (glitch_count !== 8'd0) begin
      n_err++;
      $display("FAIL midchk_glitch_clear: got %0d want 0", glitch_count);
    end
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      n_cmp++;
      if (sig_out !== (e >= 18)) begin
        n_err++;
        $display("FAIL midchk_release_sig_out_e%0d: got %b want %b", e, sig_out, (e >= 18));
      end
      n_cmp++;
      if (busy !== (e >= 3 && e <= 17)) begin
        n_err++;
        $display("FAIL midchk_release_busy_e%0d: got %b want %b", e, busy, (e >= 3 && e <= 17));
      end
    end
  endtask

`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
  task automatic test_glitch_saturate();
    int moved;
    moved = 0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      sig_in = 1'b1;
      repeat (2) @(negedge clk);
      sig_in = 1'b0;
      repeat (4) begin
        step();
        if (sig_out !== 1'b0) moved++;
      end
    end
    exp_glitch = (exp_glitch + 300 > 255) ? 255 : exp_glitch + 300;
    n_cmp++;
    if (moved !== 0) begin
      n_err++;
      $display("FAIL sat_sig_out_moved: got %0d samples high want 0", moved);
    end
    n_cmp++;
    if (glitch_count !== 8'(exp_glitch)) begin
      n_err++;
      $display("FAIL sat_glitch: got %0d want %0d", glitch_count, exp_glitch);
    end
  endtask
`endif

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    sig_in  = 1'b0;
    reset_n = 1'b1;
    test_reset();
    test_transition(1'b1, "rise");
    test_transition(1'b0, "fall");
    test_short_pulse();
    test_min_pulse();
    test_toggle();
    test_transition(1'b0, "toggle_return");
    test_reset_mid_check();
    test_transition(1'b0, "midchk_return");
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    test_glitch_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
